button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
Multi-channel push-button front end. It replaces the single-channel debouncer that feeds the Basys3 control FSMs. Each channel has:
- an input synchroniser
- polarity normalisation
- a debounce filter
- one-cycle press/release event pulses
- long-press detection and auto-repeat
Channels are fully independent. The block sits between the raw board pins (btnC/U/D/L/R) and the image-processing control logic, all in the 25 MHz clk domain.

Parameters:
NUM_CH, 5, number of independent button channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEBOUNCE_CYCLES, 250000, stable cycles required before level change (10 ms at 25 MHz, >=1)
LONG_PRESS_CYCLES, 12500000, held cycles after press before long_pulse (500 ms, >=1)
REPEAT_CYCLES, 2500000, auto-repeat period after long press (100 ms); 0 disables repeat
ACTIVE_LOW_MASK, 0, NUM_CH-bit mask; bit i=1 means channel i is pressed when raw input is 0

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
btn_in  input  NUM_CH  raw asynchronous button pins
btn_level  output  NUM_CH  debounced, normalised level (1 = pressed)
press_pulse  output  NUM_CH  one-cycle pulse on debounced press
release_pulse  output  NUM_CH  one-cycle pulse on debounced release
long_pulse  output  NUM_CH  one-cycle pulse when hold reaches LONG_PRESS_CYCLES
repeat_pulse  output  NUM_CH  one-cycle periodic pulse while held past long press

Behaviour:
- Reset (reset=1 at a clk edge):
  - sync flops of channel i load ACTIVE_LOW_MASK[i] (the inactive raw value)
  - candidate, all outputs and all counters go to 0
- Reset mid-operation aborts any debounce/hold in progress. No release_pulse is generated. A still-pressed button needs a full debounce after reset deasserts.
- Normalisation: norm[i] = sync_out[i] XOR ACTIVE_LOW_MASK[i].
- Debounce, per channel, every edge:
  - if norm != candidate: candidate <= norm, db_cnt <= 0
  - else if db_cnt < DEBOUNCE_CYCLES-1: db_cnt++
  - else if btn_level != candidate: btn_level <= candidate, and the matching press_pulse or release_pulse is asserted for exactly that cycle
- Debounce latency: raw change first sampled at edge 1 → btn_level changes at edge SYNC_STAGES+DEBOUNCE_CYCLES+1 (for a stable input).
- Glitches shorter than DEBOUNCE_CYCLES produce no level change and no pulse.
- db_cnt width = clog2(DEBOUNCE_CYCLES), minimum 1. It saturates and never wraps.
- Hold timer:
  - hold_cnt <= 0 in the press_pulse cycle and whenever btn_level=0
  - otherwise it increments, saturating at LONG_PRESS_CYCLES
  - long_pulse asserts for the one cycle in which hold_cnt first equals LONG_PRESS_CYCLES, i.e. LONG_PRESS_CYCLES cycles after press_pulse
- Repeat (REPEAT_CYCLES>0):
  - rep_cnt starts at 0 in the long_pulse cycle and counts while held
  - repeat_pulse asserts when rep_cnt reaches REPEAT_CYCLES; rep_cnt then returns to 0
  - first repeat is REPEAT_CYCLES after long_pulse, then every REPEAT_CYCLES
  - REPEAT_CYCLES=0: repeat_pulse is constant 0 and rep_cnt logic is removed
- Release precedence: in the release_pulse cycle, btn_level=0 and long_pulse, repeat_pulse and the counters are cleared. A hold ending exactly at the long threshold yields release_pulse only.
- press_pulse and release_pulse are never asserted together on one channel. Pulses on different channels may coincide.
- All outputs are registered; there is no combinational path from btn_in to any output.
- Counter widths are derived from the parameters via a constant clog2 function; there are no fixed widths.

Test Plan:
Bench parameters for all scenarios: NUM_CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW_MASK=2'b10.
- Reset, then btn_in[0] 0→1 held → btn_level[0] rises at edge 7 after the first sampling edge; press_pulse[0] high exactly 1 cycle; ch1 outputs stay 0.
- Glitch: btn_in[0]=1 for 3 cycles, then 0 → btn_level[0] stays 0; no press_pulse or release_pulse.
- Bounce: btn_in[0] toggles every 2 cycles for 12 cycles, then stays 1 → exactly one press_pulse, 7 edges after the final transition is sampled.
- Long and repeat: hold ch0 → long_pulse 10 cycles after press_pulse; repeat_pulse at +3, +6, +9 after long_pulse; release → release_pulse 7 edges after the raw fall, with no further repeat_pulse.
- Active-low ch1: btn_in[1]=1 through reset → btn_level[1]=0. Drive btn_in[1]=0 stable → press_pulse[1] after 7 edges. Return to 1 → release_pulse[1].
- Reset mid-hold: reset asserted while btn_level[0]=1 → all outputs 0 at the next edge, with no release_pulse. Deassert with the raw input still pressed → press_pulse[0] again 7 edges later.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button front end.
// Per channel: sync, polarity, debounce, press/release, long-press, repeat.
//
// Ports:
//   clk           : system clock
//   reset         : synchronous, active-high reset
//   btn_in        : raw asynchronous button pins
//   btn_level     : debounced, normalised level (1 = pressed)
//   press_pulse   : one-cycle pulse on debounced press
//   release_pulse : one-cycle pulse on debounced release
//   long_pulse    : one-cycle pulse when a hold reaches LONG_PRESS_CYCLES
//   repeat_pulse  : periodic one-cycle pulse while held past long press
module button_conditioner #(
   parameter int                NUM_CH            = 5,
   parameter int                SYNC_STAGES       = 2,
   parameter int                DEBOUNCE_CYCLES   = 250000,
   parameter int                LONG_PRESS_CYCLES = 12500000,
   parameter int                REPEAT_CYCLES     = 2500000,
   parameter logic [NUM_CH-1:0] ACTIVE_LOW_MASK   = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] btn_in,
   output logic [NUM_CH-1:0] btn_level,
   output logic [NUM_CH-1:0] press_pulse,
   output logic [NUM_CH-1:0] release_pulse,
   output logic [NUM_CH-1:0] long_pulse,
   output logic [NUM_CH-1:0] repeat_pulse
);

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int k = 0; k < 31; k++)
         if ((1 << k) < v) r = k + 1;
      return r;
   endfunction

   localparam int DB_C   = clog2(DEBOUNCE_CYCLES);
   localparam int DB_W   = (DB_C < 1) ? 1 : DB_C;
   localparam int HOLD_C = clog2(LONG_PRESS_CYCLES + 1);
   localparam int HOLD_W = (HOLD_C < 1) ? 1 : HOLD_C;

   localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   norm;
      logic                   cand_q, cand_d;
      logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
      logic                   level_q, level_d;
      logic                   press_q, press_d;
      logic                   release_q, release_d;
      logic [HOLD_W-1:0]      hold_q, hold_d;
      logic                   long_q, long_d;

      assign norm = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW_MASK[i];

      always_comb begin
         cand_d    = cand_q;
         db_cnt_d  = db_cnt_q;
         level_d   = level_q;
         press_d   = 1'b0;
         release_d = 1'b0;
         if (norm != cand_q) begin
            cand_d   = norm;
            db_cnt_d = '0;
         end else if (db_cnt_q < DB_MAX) begin
            db_cnt_d = db_cnt_q + 1'b1;
         end else if (level_q != cand_q) begin
            level_d   = cand_q;
            press_d   = cand_q;
            release_d = ~cand_q;
         end

         // A release in this cycle wins over a long-press that would
         // otherwise land on the same edge.
         hold_d = hold_q;
         long_d = 1'b0;
         if (!level_d || press_d) begin
            hold_d = '0;
         end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == HOLD_PRE);
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            sync_q    <= {SYNC_STAGES{ACTIVE_LOW_MASK[i]}};
            cand_q    <= 1'b0;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            hold_q    <= '0;
            long_q    <= 1'b0;
         end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_in[i]};
            cand_q    <= cand_d;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            hold_q    <= hold_d;
            long_q    <= long_d;
         end
      end

      assign btn_level[i]     = level_q;
      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
      assign long_pulse[i]    = long_q;

      if (REPEAT_CYCLES > 0) begin : g_rep
         localparam int REP_C = clog2(REPEAT_CYCLES);
         localparam int REP_W = (REP_C < 1) ? 1 : REP_C;
         localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

         logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
         logic             rep_q, rep_d;

         // Counting starts on the edge after long_pulse, once the hold
         // timer has saturated; any release clears it.
         always_comb begin
            rep_cnt_d = '0;
            rep_d     = 1'b0;
            if (level_d && hold_q == HOLD_MAX) begin
               if (rep_cnt_q == REP_MAX) rep_d = 1'b1;
               else rep_cnt_d = rep_cnt_q + 1'b1;
            end
         end

         always_ff @(posedge clk) begin
            if (reset) begin
               rep_cnt_q <= '0;
               rep_q     <= 1'b0;
            end else begin
               rep_cnt_q <= rep_cnt_d;
               rep_q     <= rep_d;
            end
         end

         assign repeat_pulse[i] = rep_q;
      end else begin : g_norep
         assign repeat_pulse[i] = 1'b0;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: randomised and directed checks of button_conditioner
// against a stability-window / hold-age reference model.
module tb_button_conditioner;

   localparam int NCH  = 2;
   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int LONG = 10;
   localparam int REP  = 3;
   localparam logic [1:0] MASK = 2'b10;
   localparam int LAT  = SYNC + DEB + 1;
   localparam int WIN  = SYNC + DEB + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [1:0] btn_in = 2'b10;
   logic [1:0] btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

   int vectors = 0;
   int miscompares = 0;

   bit   hist [NCH][WIN];
   int   held [NCH];
   logic [1:0] e_lvl = '0, e_prs = '0, e_rel = '0, e_lng = '0, e_rep = '0;

   wire [9:0] obs  = {btn_level, press_pulse, release_pulse, long_pulse, repeat_pulse};
   wire [9:0] want = {e_lvl, e_prs, e_rel, e_lng, e_rep};

   button_conditioner #(
      .NUM_CH(NCH), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
      .LONG_PRESS_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW_MASK(MASK)
   ) dut (
      .clk(clk), .reset(reset), .btn_in(btn_in),
      .btn_level(btn_level), .press_pulse(press_pulse),
      .release_pulse(release_pulse), .long_pulse(long_pulse),
      .repeat_pulse(repeat_pulse)
   );

   always #5 clk = ~clk;

   // Level follows the input once it has been seen unchanged for DEB+1
   // consecutive debounce samples, each sample being SYNC edges old.
   task automatic model_edge();
      int ones;
      for (int c = 0; c < NCH; c++) begin
         e_prs[c] = 1'b0; e_rel[c] = 1'b0;
         e_lng[c] = 1'b0; e_rep[c] = 1'b0;
         if (reset) begin
            for (int k = 0; k < WIN; k++) hist[c][k] = 1'b0;
            e_lvl[c] = 1'b0;
            held[c]  = 0;
         end else begin
            for (int k = 0; k < WIN - 1; k++) hist[c][k] = hist[c][k+1];
            hist[c][WIN-1] = btn_in[c] ^ MASK[c];
            ones = 0;
            for (int k = 0; k <= DEB; k++) ones += int'(hist[c][k]);
            if (!e_lvl[c] && ones == DEB + 1) begin
               e_lvl[c] = 1'b1; e_prs[c] = 1'b1; held[c] = 0;
            end else if (e_lvl[c] && ones == 0) begin
               e_lvl[c] = 1'b0; e_rel[c] = 1'b1; held[c] = 0;
            end else if (e_lvl[c]) begin
               held[c]++;
               e_lng[c] = (held[c] == LONG);
               e_rep[c] = (held[c] > LONG) && ((held[c] - LONG) % REP == 0);
            end
         end
      end
   endtask

   task automatic step(input logic [1:0] b, input logic r);
      btn_in = b;
      reset  = r;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         step(2'b10, 1'b1);
         vectors++;
         if (obs !== 10'd0) begin
            miscompares++;
            $display("FAIL reset_state edge %0d: got %b want %b", k, obs, 10'd0);
         end
      end
      for (int k = 0; k < 4; k++) begin
         step(2'b10, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_idle edge %0d: got %b want %b", k, obs, want);
         end
      end
   endtask

   task automatic test_press();
      int pe, np;
      pe = -1; np = 0;
      for (int k = 1; k <= 12; k++) begin
         step(2'b11, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL press edge %0d: got %b want %b", k, obs, want);
         end
         vectors++;
         if ({btn_level[1], press_pulse[1], release_pulse[1],
              long_pulse[1], repeat_pulse[1]} !== 5'd0) begin
            miscompares++;
            $display("FAIL press_ch1_quiet edge %0d: got %b want 00000", k,
                     {btn_level[1], press_pulse[1], release_pulse[1],
                      long_pulse[1], repeat_pulse[1]});
         end
         if (press_pulse[0] === 1'b1) begin
            np++;
            if (pe < 0) pe = k;
         end
      end
      vectors++;
      if (pe != LAT || np != 1) begin
         miscompares++;
         $display("FAIL press_latency: got edge %0d count %0d want edge %0d count 1",
                  pe, np, LAT);
      end
      for (int k = 1; k <= 10; k++) begin
         step(2'b10, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL press_release edge %0d: got %b want %b", k, obs, want);
         end
      end
   endtask

   task automatic test_glitch();
      int np;
      np = 0;
      for (int k = 1; k <= 15; k++) begin
         step((k <= DEB - 1) ? 2'b11 : 2'b10, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL glitch edge %0d: got %b want %b", k, obs, want);
         end
         np += int'(press_pulse[0] === 1'b1) + int'(release_pulse[0] === 1'b1)
             + int'(btn_level[0] !== 1'b0);
      end
      vectors++;
      if (np != 0) begin
         miscompares++;
         $display("FAIL glitch_quiet: got %0d events want 0", np);
      end
   endtask

   task automatic test_bounce();
      int pe, np;
      logic [1:0] b;
      pe = -1; np = 0;
      for (int k = 1; k <= 25; k++) begin
         b = (k > 12 || ((k - 1) / 2) % 2 == 0) ? 2'b11 : 2'b10;
         step(b, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL bounce edge %0d: got %b want %b", k, obs, want);
         end
         if (press_pulse[0] === 1'b1) begin
            np++;
            if (pe < 0) pe = k;
         end
      end
      vectors++;
      if (pe != 13 + LAT - 1 || np != 1) begin
         miscompares++;
         $display("FAIL bounce_press: got edge %0d count %0d want edge %0d count 1",
                  pe, np, 13 + LAT - 1);
      end
      for (int k = 1; k <= 10; k++) begin
         step(2'b10, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL bounce_release edge %0d: got %b want %b", k, obs, want);
         end
      end
   endtask

   task automatic test_long_repeat();
      int pe, le, re, late;
      int reps[$];
      pe = -1; le = -1; re = -1; late = 0;
      for (int k = 1; k <= LAT + LONG + 3 * REP + 1; k++) begin
         step(2'b11, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL long_hold edge %0d: got %b want %b", k, obs, want);
         end
         if (press_pulse[0] === 1'b1 && pe < 0) pe = k;
         if (long_pulse[0] === 1'b1 && le < 0) le = k;
         if (repeat_pulse[0] === 1'b1) reps.push_back(k);
      end
      vectors++;
      if (pe != LAT || le != pe + LONG) begin
         miscompares++;
         $display("FAIL long_timing: got press %0d long %0d want press %0d long %0d",
                  pe, le, LAT, LAT + LONG);
      end
      for (int j = 0; j < 3; j++) begin
         vectors++;
         if (reps.size() <= j || reps[j] != LAT + LONG + REP * (j + 1)) begin
            miscompares++;
            $display("FAIL repeat_%0d: got edge %0d want edge %0d", j,
                     (reps.size() > j) ? reps[j] : -1, LAT + LONG + REP * (j + 1));
         end
      end
      for (int k = 1; k <= 14; k++) begin
         step(2'b10, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL long_release edge %0d: got %b want %b", k, obs, want);
         end
         if (release_pulse[0] === 1'b1 && re < 0) re = k;
         if (re > 0 && k >= re && (repeat_pulse[0] !== 1'b0 || long_pulse[0] !== 1'b0))
            late++;
      end
      vectors++;
      if (re != LAT || late != 0) begin
         miscompares++;
         $display("FAIL long_release_timing: got edge %0d late %0d want edge %0d late 0",
                  re, late, LAT);
      end
   endtask

   task automatic test_active_low();
      int pe, re;
      pe = -1; re = -1;
      for (int k = 1; k <= 18; k++) begin
         step((k <= 9) ? 2'b00 : 2'b10, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL active_low edge %0d: got %b want %b", k, obs, want);
         end
         if (press_pulse[1] === 1'b1 && pe < 0) pe = k;
         if (release_pulse[1] === 1'b1 && re < 0) re = k;
      end
      vectors++;
      if (pe != LAT || re != 9 + LAT) begin
         miscompares++;
         $display("FAIL active_low_timing: got press %0d release %0d want %0d %0d",
                  pe, re, LAT, 9 + LAT);
      end
   endtask

   task automatic test_reset_mid();
      int pe, pe2, nr;
      pe = -1; pe2 = -1; nr = 0;
      for (int k = 1; k <= LAT + 3; k++) begin
         step(2'b11, 1'b0);
         if (press_pulse[0] === 1'b1 && pe < 0) pe = k;
      end
      vectors++;
      if (pe != LAT || btn_level[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_pre: got press %0d level %b want %0d 1",
                  pe, btn_level[0], LAT);
      end
      step(2'b11, 1'b1);
      vectors++;
      if (obs !== 10'd0) begin
         miscompares++;
         $display("FAIL reset_mid_clear: got %b want %b", obs, 10'd0);
      end
      for (int k = 1; k <= LAT + 3; k++) begin
         step(2'b11, 1'b0);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL reset_mid edge %0d: got %b want %b", k, obs, want);
         end
         if (press_pulse[0] === 1'b1 && pe2 < 0) pe2 = k;
         if (release_pulse[0] === 1'b1) nr++;
      end
      vectors++;
      if (pe2 != LAT || nr != 0) begin
         miscompares++;
         $display("FAIL reset_mid_repress: got edge %0d releases %0d want %0d 0",
                  pe2, nr, LAT);
      end
      for (int k = 1; k <= 10; k++) step(2'b10, 1'b0);
   endtask

   task automatic test_random();
      int left[NCH];
      logic [1:0] b;
      logic r;
      b = 2'b10;
      for (int c = 0; c < NCH; c++) left[c] = 0;
      for (int k = 1; k <= 800; k++) begin
         for (int c = 0; c < NCH; c++) begin
            if (left[c] == 0) begin
               b[c] = 1'($urandom_range(0, 1));
               left[c] = $urandom_range(1, 30);
            end
            left[c]--;
         end
         r = ($urandom_range(0, 149) == 0);
         step(b, r);
         vectors++;
         if (obs !== want) begin
            miscompares++;
            $display("FAIL random edge %0d: in %b rst %b got %b want %b",
                     k, b, r, obs, want);
         end
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_bounce();
      test_long_repeat();
      test_active_low();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got no end of run want finish before limit");
      $fatal(1, "timeout");
   end

endmodule
